// File: rtl/lifo_stack_param_pkg.sv
// Shared definitions for the parametrised LIFO stack: defaults, count-width
// helper and the push/pop operation encoding.
package lifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Count must represent 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

endpackage

// File: rtl/lifo_stack_param_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one
// combinational read port, no reset.
module lifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Address decode by comparison keeps DEPTH free of power-of-two limits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && (waddr == AW'(i))) mem_q[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == AW'(i)) rdata = mem_q[i];
    end
  end

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with occupancy count, threshold flags, swap /
// pass-through on simultaneous push+pop, and pulsed plus sticky errors.
module lifo_stack_param
  import lifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CW       = count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic             error,
  output logic             sticky_err
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             sticky_q, sticky_d;

  logic             mem_we;
  logic [CW-1:0]    mem_waddr;
  logic [CW-1:0]    top_addr;
  logic [WIDTH-1:0] top_data;
  op_e              op;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign top_addr = count_q - CW'(1);
  assign op       = op_e'({push, pop});

  lifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(CW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (data_in),
    .raddr (top_addr),
    .rdata (top_data)
  );

  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = count_q;
    unique case (op)
      OP_PUSH: begin
        if (full) overflow_d = 1'b1;
        else begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      OP_POP: begin
        if (empty) underflow_d = 1'b1;
        else begin
          data_out_d  = top_data;
          out_valid_d = 1'b1;
          count_d     = top_addr;
        end
      end
      // Swap reads the old top and overwrites it on the same edge;
      // on an empty stack the input word goes straight to the output.
      OP_SWAP: begin
        out_valid_d = 1'b1;
        if (empty) data_out_d = data_in;
        else begin
          data_out_d = top_data;
          mem_we     = 1'b1;
          mem_waddr  = top_addr;
        end
      end
      default: ;
    endcase
    if (rst) mem_we = 1'b0;
    // A new error in the same cycle as clr_err keeps the flag set.
    if (overflow_d || underflow_d) sticky_d = 1'b1;
    else if (clr_err)              sticky_d = 1'b0;
    else                           sticky_d = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      sticky_q    <= sticky_d;
    end
  end

  assign data_out     = data_out_q;
  assign out_valid    = out_valid_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign error        = overflow_q | underflow_q;
  assign sticky_err   = sticky_q;

endmodule
